// File: rtl/assoc_cache.sv
// N-way set-associative write-back / write-allocate cache between a 32-bit CPU
// port and a line-wide physical memory port, with tree PLRU replacement and perf counters.
module assoc_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int num_ways = 4,
  parameter int s_way    = $clog2(num_ways)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    mem_address,
  output logic [31:0]                    mem_rdata,
  input  logic [31:0]                    mem_wdata,
  input  logic                           mem_read,
  input  logic                           mem_write,
  input  logic [3:0]                     mem_byte_enable,
  output logic                           mem_resp,
  output logic [31:0]                    pmem_address,
  input  logic [8*(2**s_offset)-1:0]     pmem_rdata,
  output logic [8*(2**s_offset)-1:0]     pmem_wdata,
  output logic                           pmem_read,
  output logic                           pmem_write,
  input  logic                           pmem_resp,
  output logic [31:0]                    perf_hits,
  output logic [31:0]                    perf_misses,
  output logic [31:0]                    perf_writebacks
);

  localparam int num_sets = 2**s_index;
  localparam int s_line   = 8*(2**s_offset);
  localparam int s_word   = s_offset - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  state_t state_r, state_s;

  logic [s_line-1:0]   data_r  [num_ways][num_sets];
  logic [s_tag-1:0]    tag_r   [num_ways][num_sets];
  logic [num_ways-1:0] valid_r [num_sets];
  logic [num_ways-1:0] dirty_r [num_sets];
  logic [num_ways-1:1] plru_r  [num_sets];
  logic [s_way-1:0]    victim_r;
  logic [31:0]         perf_hits_r, perf_misses_r, perf_writebacks_r;

  logic [s_tag-1:0]    tag_s;
  logic [s_index-1:0]  index_s;
  logic [s_word-1:0]   word_s;
  logic [num_ways-1:0] hit_vec_s;
  logic                hit_s;
  logic [s_way-1:0]    hit_way_s;
  logic [s_way-1:0]    victim_s;
  logic [s_line-1:0]   hit_line_s;
  logic [s_line-1:0]   merged_line_s;
  logic                unused_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  // Tree bits: 0 sends the victim search to the lower half, 1 to the upper half.
  function automatic logic [s_way-1:0] pick_victim(input logic [num_ways-1:0] valid,
                                                   input logic [num_ways-1:1] tree);
    logic [s_way-1:0] way;
    logic [s_way-1:0] node;
    logic             b;
    way  = '0;
    node = s_way'(1);
    for (int l = 0; l < s_way; l++) begin
      b    = tree[node];
      way  = (way << 1) | s_way'(b);
      node = (node << 1) | s_way'(b);
    end
    for (int w = num_ways - 1; w >= 0; w--) begin
      way = valid[w] ? way : s_way'(w);
    end
    return way;
  endfunction

  function automatic logic [num_ways-1:1] plru_touch(input logic [num_ways-1:1] tree,
                                                     input logic [s_way-1:0] way);
    logic [num_ways-1:1] t;
    logic [s_way-1:0]    node;
    logic [s_way-1:0]    rest;
    logic                b;
    t    = tree;
    node = s_way'(1);
    rest = way;
    for (int l = 0; l < s_way; l++) begin
      b       = rest[s_way-1];
      t[node] = ~b;
      node    = (node << 1) | s_way'(b);
      rest    = rest << 1;
    end
    return t;
  endfunction

  function automatic logic [s_line-1:0] merge_word(input logic [s_line-1:0] line,
                                                   input logic [s_word-1:0] word,
                                                   input logic [31:0] wdata,
                                                   input logic [3:0] be);
    logic [s_line-1:0] l;
    l = line;
    for (int b = 0; b < 4; b++) begin
      l[32*int'(word) + 8*b +: 8] = be[b] ? wdata[8*b +: 8] : l[32*int'(word) + 8*b +: 8];
    end
    return l;
  endfunction

  assign tag_s    = mem_address[31 -: s_tag];
  assign index_s  = mem_address[s_offset +: s_index];
  assign word_s   = mem_address[2 +: s_word];
  assign unused_s = ^mem_address[1:0];

  assign perf_hits       = perf_hits_r;
  assign perf_misses     = perf_misses_r;
  assign perf_writebacks = perf_writebacks_r;

  // Tag compare across the indexed set, hit-way encode, victim choice and write merge.
  always_comb begin
    hit_vec_s = '0;
    hit_way_s = '0;
    for (int w = 0; w < num_ways; w++) begin
      hit_vec_s[w] = valid_r[index_s][w] && (tag_r[w][index_s] == tag_s);
      hit_way_s    = hit_way_s | (hit_vec_s[w] ? s_way'(w) : s_way'(0));
    end
    hit_s         = |hit_vec_s;
    hit_line_s    = data_r[hit_way_s][index_s];
    victim_s      = pick_victim(valid_r[index_s], plru_r[index_s]);
    merged_line_s = merge_word(hit_line_s, word_s, mem_wdata, mem_byte_enable);
  end

  // Next-state and port outputs.
  always_comb begin
    state_s      = state_r;
    mem_resp     = 1'b0;
    mem_rdata    = 32'd0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag_s, index_s, {s_offset{1'b0}}};
    pmem_wdata   = data_r[victim_r][index_s];
    case (state_r)
      IDLE: begin
        if (mem_read || mem_write) state_s = COMPARE;
        else                       state_s = IDLE;
      end
      COMPARE: begin
        if (hit_s) begin
          mem_resp  = 1'b1;
          mem_rdata = hit_line_s[32*int'(word_s) +: 32];
          state_s   = IDLE;
        end else if (valid_r[index_s][victim_s] && dirty_r[index_s][victim_s]) begin
          state_s = WRITEBACK;
        end else begin
          state_s = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_r[victim_r][index_s], index_s, {s_offset{1'b0}}};
        if (pmem_resp) state_s = FILL;
        else           state_s = WRITEBACK;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_s = COMPARE;
        else           state_s = FILL;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, per-set metadata and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      victim_r          <= '0;
      perf_hits_r       <= 32'd0;
      perf_misses_r     <= 32'd0;
      perf_writebacks_r <= 32'd0;
      for (int s = 0; s < num_sets; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else begin
      state_r <= state_s;
      case (state_r)
        COMPARE: begin
          if (hit_s) begin
            plru_r[index_s] <= plru_touch(plru_r[index_s], hit_way_s);
            perf_hits_r     <= sat_inc(perf_hits_r);
            if (mem_write) dirty_r[index_s][hit_way_s] <= 1'b1;
          end else begin
            victim_r      <= victim_s;
            perf_misses_r <= sat_inc(perf_misses_r);
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty_r[index_s][victim_r] <= 1'b0;
            perf_writebacks_r          <= sat_inc(perf_writebacks_r);
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid_r[index_s][victim_r] <= 1'b1;
            dirty_r[index_s][victim_r] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line and tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (state_r == COMPARE && hit_s && mem_write) begin
      data_r[hit_way_s][index_s] <= merged_line_s;
    end else if (state_r == FILL && pmem_resp) begin
      data_r[victim_r][index_s] <= pmem_rdata;
      tag_r[victim_r][index_s]  <= tag_s;
    end
  end

endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache. It is the successor to the direct-mapped L1 cache.
- Sits between the CPU 32-bit memory port and the 256-bit physical-memory line port.
- Adds configurable associativity, tree pseudo-LRU replacement, invalid-way-first victim selection, and hit/miss/writeback performance counters.
- Byte lane steering of the 32-bit CPU word into the 256-bit line is internal.

Parameters:
- s_offset, 5: byte-offset bits; line = 2**s_offset bytes (256 bits at default).
- s_index, 3: set-index bits; num_sets = 2**s_index.
- s_tag, 32-s_offset-s_index: tag width.
- num_ways, 4: associativity; power of two, 2 to 8.
- s_way, $clog2(num_ways): way-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_address  in  32  CPU byte address; bits [1:0] ignored.
- mem_rdata  out  32  read word, valid while mem_resp=1.
- mem_wdata  in  32  write word.
- mem_read  in  1  read request; held until mem_resp.
- mem_write  in  1  write request; held until mem_resp.
- mem_byte_enable  in  4  write byte mask.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line address; low s_offset bits zero.
- pmem_rdata  in  256  fill line.
- pmem_wdata  out  256  writeback line.
- pmem_read  out  1  fill request, held until pmem_resp.
- pmem_write  out  1  writeback request, held until pmem_resp.
- pmem_resp  in  1  physical memory completion pulse.
- perf_hits  out  32  saturating count of hit completions.
- perf_misses  out  32  saturating count of misses (one per request).
- perf_writebacks  out  32  saturating count of dirty evictions.

Behaviour:
- Reset (rst=1 at posedge) clears all valid bits, all dirty bits, all PLRU trees, and all perf counters, and forces state IDLE. Data and tag arrays are not reset.
- During and after reset, mem_resp, pmem_read and pmem_write are 0.
- Reset mid-transaction abandons the pmem transaction; any later pmem_resp while in IDLE is ignored.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL.
  - IDLE: mem_read|mem_write goes to COMPARE next cycle.
  - COMPARE: tag-match all ways of the indexed set combinationally; hit = valid & tag equal.
    - Hit: mem_resp=1 this cycle. A read drives the selected 32-bit word of the hit line. A write merges mem_wdata into the line per mem_byte_enable at the edge and sets dirty. Both update PLRU toward the hit way. Go to IDLE.
    - Miss: select victim. If the victim is valid and dirty, go to WRITEBACK; else go to FILL. Increment perf_misses once, not on the re-compare after fill.
  - WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line. On pmem_resp: clear victim dirty, increment perf_writebacks, go to FILL.
  - FILL: pmem_read=1, pmem_address={req tag, index, 0}. On pmem_resp: write pmem_rdata to the victim data, write the tag, set valid=1 and dirty=0, go to COMPARE (which then hits).
- Latency:
  - Hit: mem_resp in the 2nd cycle after the request is asserted in IDLE.
  - Clean miss: 2 + fill latency + 1 cycles.
  - Dirty miss: adds the writeback latency.
- Victim selection: the lowest-numbered invalid way if any; else the way indicated by the tree PLRU (num_ways-1 bits per set).
- PLRU update: on each hit, set the tree bits to point away from the accessed way.
- perf_hits increments on every mem_resp, including post-fill completions. All counters saturate at 32'hFFFFFFFF.
- Request rules:
  - mem_read and mem_write both high is treated as a write.
  - A write with mem_byte_enable=0 still completes and sets dirty.
  - The CPU must deassert its request after mem_resp. IDLE always spends one cycle before re-comparing, so back-to-back requests are legal.
- pmem_read and pmem_write are never high together.
- Address and write data are sampled combinationally and must stay stable until mem_resp.

Test Plan:
- Reset, then read 0x0000_0040 → FILL with pmem_address 0x0000_0040, pmem_read held until pmem_resp. mem_resp with the fill word. perf_misses=1, perf_hits=1.
- Repeat the read of 0x40 → mem_resp exactly 2 cycles after the request, no pmem activity, perf_hits=2.
- num_ways=4: fill 4 tags into set 2, then access them in order 0,1,2,0. A 5th tag evicts way 3 per PLRU; no writeback since the lines are clean.
- Write 0xDEADBEEF with byte_enable 0101 to a resident line, then evict it → WRITEBACK at the old tag address with bytes merged. perf_writebacks=1; refilling and reading returns 0x00AD00EF when the old word was 0.
- Assert rst during FILL → pmem_read=0 next cycle, counters 0, all sets invalid. A late pmem_resp is ignored and the next read misses.
- Preload perf_hits near saturation via force, drive 3 hits → holds at 0xFFFFFFFF.
